// File: rtl/cache_control_assoc_if.sv
// -----------------------------------------------------------------------------
// cache_control_assoc_if
//   Bundles the CPU-side request/response, the per-set array status, the array
//   write strobes and the physical-memory handshake of the set-associative
//   cache controller.
//
//   Parameters
//     WAYS   associativity (power of 2, >= 2)
//
//   Signals (controller view, modport slave)
//     in  : mem_read, mem_write, tag_hit, valid, dirty, lru_way, pmem_resp
//     out : mem_resp, way_sel, load_valid, load_dirty, clear_dirty, load_tag,
//           load_data, load_lru, cache_in_sel, pmem_addr_sel, pmem_read,
//           pmem_write
//   The master modport is the surrounding datapath / CPU / memory side.
// -----------------------------------------------------------------------------
interface cache_control_assoc_if #(
    parameter int WAYS = 2
);
    localparam int WAY_W = $clog2(WAYS);

    // CPU port
    logic             mem_read;
    logic             mem_write;
    logic             mem_resp;

    // Array status for the currently indexed set
    logic [WAYS-1:0]  tag_hit;
    logic [WAYS-1:0]  valid;
    logic [WAYS-1:0]  dirty;
    logic [WAY_W-1:0] lru_way;

    // Array write strobes, all applied to way_sel
    logic [WAY_W-1:0] way_sel;
    logic             load_valid;
    logic             load_dirty;
    logic             clear_dirty;
    logic             load_tag;
    logic             load_data;
    logic             load_lru;
    logic             cache_in_sel;

    // Physical memory handshake
    logic             pmem_addr_sel;
    logic             pmem_read;
    logic             pmem_write;
    logic             pmem_resp;

    modport slave (
        input  mem_read, mem_write, tag_hit, valid, dirty, lru_way, pmem_resp,
        output mem_resp, way_sel, load_valid, load_dirty, clear_dirty, load_tag,
               load_data, load_lru, cache_in_sel, pmem_addr_sel, pmem_read,
               pmem_write
    );

    modport master (
        output mem_read, mem_write, tag_hit, valid, dirty, lru_way, pmem_resp,
        input  mem_resp, way_sel, load_valid, load_dirty, clear_dirty, load_tag,
               load_data, load_lru, cache_in_sel, pmem_addr_sel, pmem_read,
               pmem_write
    );
endinterface

// File: rtl/cache_control_assoc.sv
// -----------------------------------------------------------------------------
// cache_control_assoc
//   Control FSM for a WAYS-way set-associative, write-back, write-allocate
//   cache. Detects per-way hits, chooses a victim (first invalid way, else the
//   LRU way), sequences writeback and fill over the pmem handshake, steers all
//   array write strobes through one way-select bus and keeps saturating
//   hit / miss / writeback counters.
//
//   Parameters
//     WAYS    associativity (power of 2, >= 2)
//     CNT_W   width of each performance counter
//
//   Ports
//     clk          system clock, rising edge
//     rst          asynchronous, active-high reset
//     bus          cache_control_assoc_if.slave (CPU, array and pmem signals)
//     clr_counts   synchronous clear of the three counters (wins over +1)
//     hit_count    saturating count of hit cycles with a request
//     miss_count   saturating count of miss cycles with a request
//     wb_count     saturating count of writebacks started
// -----------------------------------------------------------------------------
module cache_control_assoc #(
    parameter int WAYS  = 2,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    cache_control_assoc_if.slave  bus,
    input  logic                  clr_counts,
    output logic [CNT_W-1:0]      hit_count,
    output logic [CNT_W-1:0]      miss_count,
    output logic [CNT_W-1:0]      wb_count
);
    localparam int WAY_W = $clog2(WAYS);

    typedef enum logic [1:0] {
        ACCESS    = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WAY_W-1:0] victim_q, victim_d;

    logic             req;
    logic [WAYS-1:0]  hitvec;
    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] victim;
    logic             victim_dirty;
    logic             hit_inc, miss_inc, wb_inc;

    // -------------------------------------------------------------------------
    // Hit detection and victim selection (pure combinational per-set decode)
    // -------------------------------------------------------------------------
    assign req    = bus.mem_read | bus.mem_write;
    assign hitvec = bus.tag_hit & bus.valid;
    assign hit    = |hitvec;

    // Scanning from the top down leaves the lowest matching index last, so it
    // wins; when nothing matches the default stands.
    always_comb begin
        hit_way = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (hitvec[i]) hit_way = WAY_W'(i);
        end
    end

    always_comb begin
        victim = bus.lru_way;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!bus.valid[i]) victim = WAY_W'(i);
        end
    end

    // Only the LRU fallback can pick a valid way, so this is effectively
    // "all ways valid and the LRU way is dirty".
    assign victim_dirty = bus.valid[victim] & bus.dirty[victim];

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ACCESS;
            victim_q <= '0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and outputs
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first; a path that skips
    // an assignment would otherwise infer a latch.
    always_comb begin
        state_d           = state_q;
        victim_d          = victim_q;
        hit_inc           = 1'b0;
        miss_inc          = 1'b0;
        wb_inc            = 1'b0;

        bus.mem_resp      = 1'b0;
        bus.load_valid    = 1'b0;
        bus.load_dirty    = 1'b0;
        bus.clear_dirty   = 1'b0;
        bus.load_tag      = 1'b0;
        bus.load_data     = 1'b0;
        bus.load_lru      = 1'b0;
        bus.cache_in_sel  = 1'b0;
        bus.pmem_addr_sel = 1'b0;
        bus.pmem_read     = 1'b0;
        bus.pmem_write    = 1'b0;
        bus.way_sel       = (state_q == ACCESS) ? hit_way : victim_q;

        unique case (state_q)
            ACCESS: begin
                if (req && hit) begin
                    hit_inc      = 1'b1;
                    bus.mem_resp = 1'b1;
                    bus.load_lru = 1'b1;
                    // A simultaneous read and write is served as a read.
                    if (bus.mem_write && !bus.mem_read) begin
                        bus.load_data    = 1'b1;
                        bus.load_dirty   = 1'b1;
                        bus.cache_in_sel = 1'b1;
                    end
                end else if (req) begin
                    // Miss cycle: latch the victim, touch no array.
                    miss_inc = 1'b1;
                    victim_d = victim;
                    if (victim_dirty) begin
                        wb_inc  = 1'b1;
                        state_d = WRITEBACK;
                    end else begin
                        state_d = FILL;
                    end
                end
            end

            WRITEBACK: begin
                bus.pmem_write    = 1'b1;
                bus.pmem_addr_sel = 1'b1;
                if (bus.pmem_resp) state_d = FILL;
            end

            FILL: begin
                bus.pmem_read = 1'b1;
                bus.load_tag  = 1'b1;
                if (bus.pmem_resp) begin
                    bus.load_data   = 1'b1;
                    bus.load_valid  = 1'b1;
                    bus.clear_dirty = 1'b1;
                    state_d         = ACCESS;
                end
            end

            default: state_d = ACCESS;
        endcase
    end

    // -------------------------------------------------------------------------
    // Saturating performance counters
    // -------------------------------------------------------------------------
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else if (clr_counts) begin
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else begin
            if (hit_inc)  hit_count  <= sat_inc(hit_count);
            if (miss_inc) miss_count <= sat_inc(miss_count);
            if (wb_inc)   wb_count   <= sat_inc(wb_count);
        end
    end

endmodule

// File: tb/tb_cache_control_assoc.sv
// -----------------------------------------------------------------------------
// tb_cache_control_assoc
//   Self-checking bench for cache_control_assoc (WAYS=4, CNT_W=4). A
//   behavioural model tracks the miss phase, the chosen victim and the
//   counters; a compare process checks every DUT output against it on each
//   falling edge. Directed sequences with literal expectations pin the model,
//   then a randomized phase exercises the controller with held requests.
// -----------------------------------------------------------------------------
module tb_cache_control_assoc;
    localparam int WAYS    = 4;
    localparam int CNT_W   = 4;
    localparam int WAY_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    // Model phases of a request
    localparam int PH_ACCESS = 0;
    localparam int PH_WB     = 1;
    localparam int PH_FILL   = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             clr_counts;
    logic [CNT_W-1:0] hit_count, miss_count, wb_count;

    cache_control_assoc_if #(.WAYS(WAYS)) bus ();

    cache_control_assoc #(.WAYS(WAYS), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .clr_counts (clr_counts),
        .hit_count  (hit_count),
        .miss_count (miss_count),
        .wb_count   (wb_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Behavioural model
    // -------------------------------------------------------------------------
    int  m_phase  = PH_ACCESS;
    int  m_victim = 0;
    int  m_hits   = 0;
    int  m_misses = 0;
    int  m_wbs    = 0;
    bit  chk_en   = 1'b0;
    bit  last_resp = 1'b0;

    typedef struct {
        bit resp;
        int way;
        bit way_known;
        bit lv, ldirty, cd, lt, ldata, llru, cis, pas, pr, pw;
    } exp_t;

    function automatic int lowest_set(input logic [WAYS-1:0] v, input int dflt);
        for (int i = 0; i < WAYS; i++) if (v[i]) return i;
        return dflt;
    endfunction

    function automatic int sat(input int x);
        return (x < CNT_MAX) ? x + 1 : CNT_MAX;
    endfunction

    function automatic exp_t expect_now();
        exp_t e;
        logic [WAYS-1:0] hv;
        bit req, rd_only_wr;
        e = '{default: 0};
        hv  = bus.tag_hit & bus.valid;
        req = bus.mem_read || bus.mem_write;
        rd_only_wr = bus.mem_write && !bus.mem_read;
        case (m_phase)
            PH_ACCESS: begin
                if (hv != 0) begin
                    e.way = lowest_set(hv, 0);
                    e.way_known = 1;
                    if (req) begin
                        e.resp = 1;
                        e.llru = 1;
                        if (rd_only_wr) begin
                            e.ldata  = 1;
                            e.ldirty = 1;
                            e.cis    = 1;
                        end
                    end
                end
            end
            PH_WB: begin
                e.pw = 1; e.pas = 1;
                e.way = m_victim; e.way_known = 1;
            end
            default: begin
                e.pr = 1; e.lt = 1;
                e.way = m_victim; e.way_known = 1;
                if (bus.pmem_resp) begin
                    e.ldata = 1; e.lv = 1; e.cd = 1;
                end
            end
        endcase
        return e;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase  = PH_ACCESS;
            m_victim = 0;
            m_hits   = 0;
            m_misses = 0;
            m_wbs    = 0;
        end else begin
            case (m_phase)
                PH_ACCESS: begin
                    if (bus.mem_read || bus.mem_write) begin
                        if ((bus.tag_hit & bus.valid) != 0) begin
                            m_hits = sat(m_hits);
                        end else begin
                            m_misses = sat(m_misses);
                            m_victim = lowest_set(~bus.valid, int'(bus.lru_way));
                            if (bus.valid[m_victim] && bus.dirty[m_victim]) begin
                                m_phase = PH_WB;
                                m_wbs   = sat(m_wbs);
                            end else begin
                                m_phase = PH_FILL;
                            end
                        end
                    end
                end
                PH_WB:   if (bus.pmem_resp) m_phase = PH_FILL;
                default: if (bus.pmem_resp) m_phase = PH_ACCESS;
            endcase
            if (clr_counts) begin
                m_hits = 0; m_misses = 0; m_wbs = 0;
            end
        end
    end

    // Compare process: outputs are sampled half a cycle away from the edge.
    always @(negedge clk) begin
        exp_t e;
        e = expect_now();
        last_resp = rst ? 1'b0 : e.resp;
        if (!rst && chk_en) begin
            check("mem_resp",      bus.mem_resp,      e.resp);
            if (e.way_known) check("way_sel", bus.way_sel, e.way);
            check("load_valid",    bus.load_valid,    e.lv);
            check("load_dirty",    bus.load_dirty,    e.ldirty);
            check("clear_dirty",   bus.clear_dirty,   e.cd);
            check("load_tag",      bus.load_tag,      e.lt);
            check("load_data",     bus.load_data,     e.ldata);
            check("load_lru",      bus.load_lru,      e.llru);
            check("cache_in_sel",  bus.cache_in_sel,  e.cis);
            check("pmem_addr_sel", bus.pmem_addr_sel, e.pas);
            check("pmem_read",     bus.pmem_read,     e.pr);
            check("pmem_write",    bus.pmem_write,    e.pw);
            check("hit_count",     hit_count,         m_hits);
            check("miss_count",    miss_count,        m_misses);
            check("wb_count",      wb_count,          m_wbs);
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic rd, input logic wr, input logic [WAYS-1:0] th,
                          input logic [WAYS-1:0] vl, input logic [WAYS-1:0] dt,
                          input logic [WAY_W-1:0] lru);
        bus.mem_read  = rd;
        bus.mem_write = wr;
        bus.tag_hit   = th;
        bus.valid     = vl;
        bus.dirty     = dt;
        bus.lru_way   = lru;
    endtask

    initial begin
        bit pending;
        rst = 1'b1;
        clr_counts = 1'b0;
        bus.pmem_resp = 1'b0;
        set_in(0, 0, '0, '0, '0, '0);

        // Reset state
        #3;
        check("rst hit_count",  hit_count,      0);
        check("rst miss_count", miss_count,     0);
        check("rst wb_count",   wb_count,       0);
        check("rst mem_resp",   bus.mem_resp,   0);
        check("rst pmem_read",  bus.pmem_read,  0);
        check("rst pmem_write", bus.pmem_write, 0);
        #4;
        rst = 1'b0;
        chk_en = 1'b1;

        // Read hit with read+write both asserted: lowest hitting way, read behaviour
        tick();
        set_in(1, 1, 4'b0110, 4'b1111, 4'b0000, 2'd0);
        #1;
        check("hit way_sel",       bus.way_sel,      1);
        check("hit mem_resp",      bus.mem_resp,     1);
        check("hit load_lru",      bus.load_lru,     1);
        check("rdwr load_data",    bus.load_data,    0);
        check("rdwr cache_in_sel", bus.cache_in_sel, 0);
        tick();
        set_in(0, 0, '0, 4'b1111, '0, 2'd0);
        #1;
        check("hit_count after hit", hit_count, 1);

        // Clean write miss: victim = first invalid way (2)
        set_in(0, 1, 4'b0000, 4'b1011, 4'b0000, 2'd0);
        #1;
        check("miss mem_resp",  bus.mem_resp,  0);
        check("miss load_data", bus.load_data, 0);
        tick();
        bus.valid = 4'b1111;
        #1;
        check("fill way_sel",    bus.way_sel,   2);
        check("fill pmem_read",  bus.pmem_read, 1);
        check("fill load_tag",   bus.load_tag,  1);
        check("fill load_data",  bus.load_data, 0);
        check("miss_count 1",    miss_count,    1);
        tick();
        tick();
        bus.pmem_resp = 1'b1;
        #1;
        check("fill done load_data",   bus.load_data,   1);
        check("fill done load_valid",  bus.load_valid,  1);
        check("fill done clear_dirty", bus.clear_dirty, 1);
        check("fill done way_sel",     bus.way_sel,     2);
        tick();
        bus.pmem_resp = 1'b0;
        bus.tag_hit   = 4'b0100;
        #1;
        check("merge mem_resp",     bus.mem_resp,     1);
        check("merge cache_in_sel", bus.cache_in_sel, 1);
        check("merge load_dirty",   bus.load_dirty,   1);
        check("merge way_sel",      bus.way_sel,      2);
        check("merge pmem_read",    bus.pmem_read,    0);
        tick();
        set_in(0, 0, '0, 4'b1111, '0, 2'd0);
        #1;
        check("hit_count 2",  hit_count,  2);
        check("miss_count 1b", miss_count, 1);

        // Dirty miss with all ways valid: victim = lru_way (3)
        set_in(1, 0, 4'b0000, 4'b1111, 4'b1111, 2'd3);
        tick();
        #1;
        check("wb pmem_write",    bus.pmem_write,    1);
        check("wb pmem_addr_sel", bus.pmem_addr_sel, 1);
        check("wb way_sel",       bus.way_sel,       3);
        check("wb_count 1",       wb_count,          1);
        bus.lru_way = 2'd0;
        tick();
        #1;
        check("wb way_sel stable", bus.way_sel, 3);
        bus.pmem_resp = 1'b1;
        tick();
        bus.pmem_resp = 1'b0;
        #1;
        check("wb->fill pmem_write", bus.pmem_write, 0);
        check("wb->fill pmem_read",  bus.pmem_read,  1);
        check("wb->fill way_sel",    bus.way_sel,    3);

        // Asynchronous reset in FILL cycle 2
        tick();
        #1;
        rst = 1'b1;
        #1;
        check("rst fill pmem_read", bus.pmem_read, 0);
        check("rst fill load_tag",  bus.load_tag,  0);
        check("rst fill hit",       hit_count,     0);
        check("rst fill miss",      miss_count,    0);
        check("rst fill wb",        wb_count,      0);
        #2;
        rst = 1'b0;
        tick();
        #1;
        check("re-miss miss_count", miss_count,     1);
        check("re-miss pmem_write", bus.pmem_write, 1);
        check("re-miss way_sel",    bus.way_sel,    0);
        bus.mem_read  = 1'b0;
        bus.pmem_resp = 1'b1;
        tick();
        tick();
        bus.pmem_resp = 1'b0;
        #1;
        check("drop pmem_read",  bus.pmem_read,  0);
        check("drop pmem_write", bus.pmem_write, 0);

        // Saturation and clear priority
        clr_counts = 1'b1;
        tick();
        clr_counts = 1'b0;
        set_in(1, 0, 4'b0001, 4'b1111, 4'b0000, 2'd0);
        #1;
        check("clr hit_count", hit_count, 0);
        repeat (17) tick();
        check("sat hit_count", hit_count, 15);
        clr_counts = 1'b1;
        tick();
        clr_counts = 1'b0;
        check("clr wins hit_count", hit_count, 0);
        set_in(0, 0, '0, '0, '0, '0);

        // Randomized phase with held requests
        pending = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (!pending || last_resp) begin
                pending = ($urandom_range(0, 1) == 1);
                bus.mem_read  = pending && ($urandom_range(0, 2) != 0);
                bus.mem_write = pending && (!bus.mem_read || $urandom_range(0, 3) == 0);
            end
            bus.tag_hit   = WAYS'($urandom);
            bus.valid     = WAYS'($urandom | $urandom);
            bus.dirty     = WAYS'($urandom);
            bus.lru_way   = WAY_W'($urandom);
            bus.pmem_resp = ($urandom_range(0, 2) == 0);
            clr_counts    = ($urandom_range(0, 63) == 0);
            if (c == 1500) begin
                #2 rst = 1'b1;
                #3 rst = 1'b0;
            end
        end

        set_in(0, 0, '0, '0, '0, '0);
        bus.pmem_resp = 1'b0;
        clr_counts    = 1'b0;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cache_control_assoc.md
# cache_control_assoc

Parametrised control FSM for a WAYS-way set-associative, write-back, write-allocate cache. It sits between the CPU-side memory port and physical memory, beside the tag, valid, dirty, data and LRU arrays. It detects hits per way and picks a victim way (first invalid way, otherwise the LRU way). It sequences writeback and fill over the pmem handshake, drives every array write strobe through a single way-select bus, and keeps saturating hit, miss and writeback counters.

## Interface
- WAYS, 2: associativity, a power of 2 and at least 2. WAY_W = $clog2(WAYS).
- CNT_W, 16: width of each performance counter.

- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- mem_read  in  1  CPU read request, held until mem_resp
- mem_write  in  1  CPU write request, held until mem_resp
- tag_hit  in  WAYS  per-way tag-compare result for the current set
- valid  in  WAYS  per-way valid bits of the current set
- dirty  in  WAYS  per-way dirty bits of the current set
- lru_way  in  WAY_W  replacement candidate from the LRU array
- pmem_resp  in  1  physical memory done, one-cycle pulse
- clr_counts  in  1  synchronous counter clear
- mem_resp  out  1  CPU request complete
- way_sel  out  WAY_W  way targeted by all array loads and by the read-data mux
- load_valid, load_dirty, clear_dirty, load_tag, load_data, load_lru  out  1 each  array write strobes, all applied to way_sel
- cache_in_sel  out  1  0 = fill line from pmem, 1 = merge CPU write data
- pmem_addr_sel  out  1  0 = CPU address, 1 = victim tag (writeback) address
- pmem_read, pmem_write  out  1  physical memory request, held until pmem_resp
- hit_count, miss_count, wb_count  out  CNT_W  performance counters

## Operation
- States: ACCESS, WRITEBACK, FILL. Reset state is ACCESS.
- Registers: state, victim_q (WAY_W), and three counters. All are 0 on reset.
- Every output is 0 by default. way_sel is hit_way in ACCESS and victim_q elsewhere.
- req = mem_read | mem_write. If both are asserted, the request is handled as a read.
- hitvec = tag_hit & valid. hit = |hitvec. hit_way = lowest set index of hitvec.
- ACCESS with no request: no strobes asserted, stay in ACCESS.
- ACCESS, read hit: mem_resp=1, load_lru=1, stay in ACCESS.
- ACCESS, write hit: mem_resp, load_lru, load_data, load_dirty and cache_in_sel all 1. Stay in ACCESS.
- ACCESS, miss: victim = lowest index with valid=0. If every way is valid, victim = lru_way.
  - Register victim into victim_q.
  - If valid[victim] and dirty[victim], go to WRITEBACK; otherwise go to FILL.
  - No strobes assert in the miss cycle.
- WRITEBACK: pmem_write=1, pmem_addr_sel=1. On pmem_resp go to FILL, else stay.
- FILL: pmem_read=1, load_tag=1.
  - On pmem_resp: load_data, load_valid and clear_dirty pulse, then go to ACCESS.
  - Otherwise stay in FILL.
- After FILL the held request is re-evaluated in ACCESS and resolves as a hit. The write merge happens on that hit cycle.
- Counters:
  - hit_count increments on each hit cycle with req=1.
  - miss_count increments on each ACCESS miss cycle with req=1.
  - wb_count increments on each ACCESS to WRITEBACK transition.
  - Counters saturate at all-ones. clr_counts zeroes all three and wins over a same-cycle increment.
- If req drops during WRITEBACK or FILL, the controller still completes the pmem transaction and returns to ACCESS.

## Timing
- Hit: mem_resp is combinational in the request cycle. Zero added latency.
- Clean miss, with pmem_resp arriving k cycles after FILL entry: 1 (miss) + k (FILL) + 1 (hit) cycles, so mem_resp comes k+2 cycles after the request starts.
- Dirty miss: adds WRITEBACK cycles up to and including its pmem_resp.
- pmem_read/pmem_write stay high continuously from state entry through the pmem_resp cycle. They drop in the following cycle.
- victim_q is stable for the whole miss; changes to lru_way or valid after the miss cycle are ignored.
- rst mid-miss: state becomes ACCESS, victim_q 0 and counters 0 immediately (asynchronously). pmem_read/pmem_write deassert in the same instant.

## Test plan
- WAYS=2, valid=2'b11, tag_hit=2'b10, mem_read=1 -> same cycle: mem_resp=1, load_lru=1, way_sel=1. hit_count goes 0 to 1.
- WAYS=4, valid=4'b1011, no hit, mem_write=1 -> victim 2, FILL with way_sel=2. pmem_resp after 3 cycles pulses load_data/load_valid/clear_dirty. Next cycle is a write hit with cache_in_sel=1 and load_dirty=1. miss_count=1.
- WAYS=4, all valid and dirty, lru_way=3, miss -> WRITEBACK: pmem_write=1, pmem_addr_sel=1, way_sel=3. After pmem_resp go to FILL. lru_way changed to 0 mid-miss leaves way_sel at 3. wb_count=1.
- Assert rst during FILL cycle 2 -> pmem_read=0 and state ACCESS immediately, counters 0. After release, the held mem_read misses again.
- CNT_W=4: 17 consecutive hits -> hit_count holds 15. Assert clr_counts together with a hit -> hit_count=0.
- tag_hit=4'b0110, valid=4'b1111, read -> way_sel=1. mem_read and mem_write both high on a hit -> read behaviour, load_data=0.
